// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the synchronous FIFO: credit-gated fifo_rd_en feeding a 2-entry skid
// buffer on a valid/ready stream. Define FIFO_RD_CTRL_STATS_EN to build rd_count/err_count.
module fifo_rd_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  inflight_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;

  logic       pop;
  logic       push;
  logic [1:0] credit_occ;
  logic       drain_done;

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf0_q;
  assign busy    = busy_q;

  assign pop  = m_valid && m_ready;
  assign push = inflight_q && !fifo_underflow;

  // Occupancy once the in-flight word lands and this cycle's pop leaves; max value 3 fits 2 bits.
  assign credit_occ = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fifo_rd_en = (state_q == StActive) && enable && !fifo_empty && (credit_occ < 2'd2);

  // Empty after this edge: nothing in flight and the last buffered word (if any) pops now.
  assign drain_done = !inflight_q && (buf_cnt_q == {1'b0, pop});

  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = fifo_data_out;
        end else begin
          buf1_d = fifo_data_out;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StActive;
            busy_q  <= 1'b1;
          end
        end
        StActive: begin
          if (!enable) begin
            if (m_valid || inflight_q) begin
              state_q <= StDrain;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (enable) begin
            state_q <= StActive;
          end else if (drain_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] rd_count_q;
  logic [CNT_WIDTH-1:0] err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      if (pop) begin
        rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      end
      if (inflight_q && fifo_underflow) begin
        err_count_q <= err_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;
`else
  assign rd_count  = '0;
  assign err_count = '0;
`endif

  // Buffered plus in-flight words never exceed the two buffer slots.
  assert property (@(posedge clk) disable iff (!rst_n)
                   ({1'b0, buf_cnt_q} + {2'b00, inflight_q}) <= 3'd2);

  assert property (@(posedge clk) disable iff (!rst_n)
                   (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
